cpu_result_reader: RTL

- Memory-side readback engine; the read-out counterpart of the CPU driver that preloads data memory and releases the CPU from reset.
- Snoops CPU store traffic for a completion write to DONE_ADR. On that write it holds the CPU in reset and reads the result words back from data memory over the external port.
- Streams the results out byte-by-byte on a valid/ready interface, e.g. to a UART or LED driver.

---
 rtl/cpu_result_reader_if.sv | 26 ++
 rtl/cpu_result_reader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cpu_result_reader_if.sv
// Bundles the snooped CPU store bus, the external read port, the byte stream
// and the status lines of cpu_result_reader. master = reader, slave = environment.
interface cpu_result_reader_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        Ext_MemRead;
    logic [31:0] Ext_ReadAdr;
    logic [31:0] Ext_ReadData;
    logic        cpu_hold;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    modport master (
        input  MemWrite, DataAdr, WriteData, Ext_ReadData, out_ready,
        output Ext_MemRead, Ext_ReadAdr, cpu_hold, out_data, out_valid, busy, done
    );

    modport slave (
        output MemWrite, DataAdr, WriteData, Ext_ReadData, out_ready,
        input  Ext_MemRead, Ext_ReadAdr, cpu_hold, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/cpu_result_reader.sv
// Snoops a CPU "results ready" store, holds the CPU, reads result words back and
// streams them LSB-first over valid/ready. Macro RESULT_CHECKSUM_EN appends an XOR byte.
module cpu_result_reader #(
    parameter logic [31:0] DONE_ADR  = 32'h0200_0004,
    parameter logic [31:0] RES_BASE  = 32'h0200_0010,
    parameter int unsigned MAX_WORDS = 8,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                reset,
    cpu_result_reader_if.master bus
);
    localparam int IW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SEND, S_FIN} state_t;

    state_t        r_state;
    logic [IW-1:0] r_cnt;
    logic [IW-1:0] r_word_idx;
    logic [1:0]    r_byte_idx;
    logic [2:0]    r_wait;
    logic [31:0]   r_word;
    logic          r_ext_memread;
    logic [31:0]   r_ext_readadr;
    logic          r_cpu_hold;
    logic [7:0]    r_out_data;
    logic          r_out_valid;
    logic          r_busy;
    logic          r_done;
`ifdef RESULT_CHECKSUM_EN
    logic [7:0]    r_csum;
    logic          r_csum_phase;
`endif

    logic          w_trigger;
    logic          w_handshake;
    logic          w_csum_byte;
    logic [IW-1:0] w_cnt_in;
    logic [IW-1:0] w_next_idx;
    logic          w_unused;

    assign w_trigger   = bus.MemWrite && (bus.DataAdr == DONE_ADR);
    assign w_handshake = r_out_valid && bus.out_ready;
    assign w_cnt_in    = (32'(bus.WriteData[3:0]) > MAX_WORDS) ? IW'(MAX_WORDS)
                                                               : IW'(bus.WriteData[3:0]);
    assign w_next_idx  = r_word_idx + 1'b1;
    assign w_unused    = ^bus.WriteData[31:4];
`ifdef RESULT_CHECKSUM_EN
    assign w_csum_byte = r_csum_phase;
`else
    assign w_csum_byte = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_word_idx    <= '0;
            r_byte_idx    <= '0;
            r_wait        <= '0;
            r_word        <= '0;
            r_ext_memread <= 1'b0;
            r_ext_readadr <= '0;
            r_cpu_hold    <= 1'b0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
            r_csum        <= '0;
            r_csum_phase  <= 1'b0;
`endif
        end else begin
            // NOTE: pulse outputs default low here; a later non-blocking assignment in the case overrides it.
            r_ext_memread <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_cnt      <= w_cnt_in;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                        r_cpu_hold <= 1'b1;
                        r_busy     <= 1'b1;
`ifdef RESULT_CHECKSUM_EN
                        r_csum     <= '0;
`endif
                        if (w_cnt_in == '0) begin
`ifdef RESULT_CHECKSUM_EN
                            r_csum_phase <= 1'b1;
                            r_out_data   <= 8'h00;
                            r_out_valid  <= 1'b1;
                            r_state      <= S_SEND;
`else
                            r_state      <= S_FIN;
`endif
                        end else begin
                            r_ext_memread <= 1'b1;
                            r_ext_readadr <= RES_BASE;
                            r_state       <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_wait  <= 3'd1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == 3'(RD_LAT)) begin
                        r_word      <= bus.Ext_ReadData;
                        r_out_data  <= bus.Ext_ReadData[7:0];
                        r_out_valid <= 1'b1;
                        r_byte_idx  <= '0;
                        r_state     <= S_SEND;
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                S_SEND: begin
                    if (w_handshake) begin
`ifdef RESULT_CHECKSUM_EN
                        r_csum <= r_csum ^ r_out_data;
`endif
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_word     <= r_word >> 8;
                        r_out_data <= r_word[15:8];
                        if (w_csum_byte) begin
`ifdef RESULT_CHECKSUM_EN
                            r_csum_phase <= 1'b0;
`endif
                            r_out_valid <= 1'b0;
                            r_state     <= S_FIN;
                        end else if (r_byte_idx == 2'd3) begin
                            r_word_idx <= w_next_idx;
                            if (w_next_idx < r_cnt) begin
                                r_out_valid   <= 1'b0;
                                r_ext_memread <= 1'b1;
                                r_ext_readadr <= RES_BASE + (32'(w_next_idx) << 2);
                                r_state       <= S_REQ;
                            end else begin
`ifdef RESULT_CHECKSUM_EN
                                // Checksum covers the byte being accepted right now.
                                r_csum_phase <= 1'b1;
                                r_out_data   <= r_csum ^ r_out_data;
`else
                                r_out_valid  <= 1'b0;
                                r_state      <= S_FIN;
`endif
                            end
                        end
                    end
                end
                S_FIN: begin
                    r_done      <= 1'b1;
                    r_cpu_hold  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Ext_MemRead = r_ext_memread;
    assign bus.Ext_ReadAdr = r_ext_readadr;
    assign bus.cpu_hold    = r_cpu_hold;
    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
endmodule
